// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   state_t   - controller states (IDLE, CALC, FIX)
//   WIDTH_DEF - default operand / HI / LO width
//   cnt_w()   - iteration counter width for a given operand width
//   CNT_W     - counter width at the default operand width
package muldiv_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    function automatic int unsigned cnt_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_w(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the unsigned multiply/divide
// datapath.
//   mul0_div1_sel - 0: shift-add multiply step, 1: restoring divide step
//   acc           - upper half (partial product / partial remainder)
//   q             - lower half (multiplier bits / dividend-quotient bits)
//   opnd          - multiplicand or divisor magnitude
//   acc_nxt,q_nxt - state after this iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             mul0_div1_sel,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, opnd};
        shifted = {acc, q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        acc_nxt = acc;
        q_nxt   = q;
        if (!mul0_div1_sel) begin
            // {acc,q} shifts right one place; the carry out of the add
            // becomes the new top bit of acc.
            if (q[0]) begin
                {acc_nxt, q_nxt} = {sum, q[WIDTH-1:1]};
            end else begin
                {acc_nxt, q_nxt} = {1'b0, acc, q[WIDTH-1:1]};
            end
        end else begin
            // diff[WIDTH] is the borrow: set means the trial subtract failed
            // and the shifted remainder is kept (restored).
            if (!diff[WIDTH]) begin
                acc_nxt = diff[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MIPS-style HI/LO multiply/divide unit.
// Operation takes WIDTH iterations in CALC plus one FIX cycle that applies
// sign correction and writes HI/LO. Divide by zero skips CALC.
// Optional build macro: MULDIV_MTHI_MTLO_EN adds MTHI/MTLO write ports.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - EX-stage mult/div valid
//   mul0_div1_sel     - 0 multiply, 1 divide
//   unsigned_op       - 1 unsigned, 0 signed
//   rs_data, rt_data  - operands (rs dividend, rt divisor)
//   hilo_rd           - EX-stage MFHI/MFLO valid
//   hi0_lo1_sel       - read select, 0 HI, 1 LO
//   flush             - abort in-flight operation
//   hilo_wr, hilo_wr_sel, hilo_wr_data - MTHI/MTLO (macro builds only)
//   busy              - operation in flight
//   stall             - hold EX and earlier stages
//   hilo_rdata        - selected HI/LO register
//   done              - pulse in the cycle HI/LO are written
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mul0_div1_sel,
    input  logic             unsigned_op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hilo_rd,
    input  logic             hi0_lo1_sel,
    input  logic             flush,
`ifdef MULDIV_MTHI_MTLO_EN
    input  logic             hilo_wr,
    input  logic             hilo_wr_sel,
    input  logic [WIDTH-1:0] hilo_wr_data,
`endif
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic             done
);

    localparam int unsigned CW = cnt_w(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qreg;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;

    logic             load;
    logic             load_div0;
    logic             iter;
    logic             fix_wr;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_MTHI_MTLO_EN
    logic             mt_wr;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mul0_div1_sel (is_div),
        .acc           (acc),
        .q             (qreg),
        .opnd          (opnd),
        .acc_nxt       (acc_step),
        .q_nxt         (q_step)
    );

    // Operand magnitudes and signs
    always_comb begin
        rs_neg = ~unsigned_op & rs_data[WIDTH-1];
        rt_neg = ~unsigned_op & rt_data[WIDTH-1];
        rs_mag = rs_neg ? (~rs_data + 1'b1) : rs_data;
        rt_mag = rt_neg ? (~rt_data + 1'b1) : rt_data;
    end

    // Sign correction of the magnitude result held in {acc,qreg}.
    // The signed-overflow divide needs no special case: its quotient
    // magnitude is 2^(WIDTH-1), which negates to itself.
    always_comb begin
        prod   = {acc, qreg};
        fix_hi = acc;
        fix_lo = qreg;
        if (!is_div) begin
            if (neg_lo) begin
                prod = ~prod + 1'b1;
            end
            {fix_hi, fix_lo} = prod;
        end else begin
            if (neg_lo) begin
                fix_lo = ~qreg + 1'b1;
            end
            if (neg_hi) begin
                fix_hi = ~acc + 1'b1;
            end
        end
    end

    // Next state and control strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_div0 = 1'b0;
        iter      = 1'b0;
        fix_wr    = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mul0_div1_sel && (rt_data == '0)) begin
                            load_div0 = 1'b1;
                            state_nxt = FIX;
                        end else begin
                            load      = 1'b1;
                            state_nxt = CALC;
                        end
                    end
                end
                CALC: begin
                    iter = 1'b1;
                    if (cnt == '0) begin
                        state_nxt = FIX;
                    end
                end
                FIX: begin
                    fix_wr    = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef MULDIV_MTHI_MTLO_EN
    assign mt_wr = (state == IDLE) && hilo_wr && !start && !flush;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            qreg   <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt    <= CW'(WIDTH - 1);
                is_div <= mul0_div1_sel;
                acc    <= '0;
                neg_lo <= rs_neg ^ rt_neg;
                neg_hi <= rs_neg;
                if (mul0_div1_sel) begin
                    qreg <= rs_mag;
                    opnd <= rt_mag;
                end else begin
                    qreg <= rt_mag;
                    opnd <= rs_mag;
                end
            end else if (load_div0) begin
                // FIX then writes HI = rs_data, LO = all-ones unchanged.
                is_div <= 1'b1;
                acc    <= rs_data;
                qreg   <= '1;
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
            end else if (iter) begin
                acc  <= acc_step;
                qreg <= q_step;
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (fix_wr) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
`ifdef MULDIV_MTHI_MTLO_EN
            else if (mt_wr) begin
                if (hilo_wr_sel) begin
                    lo <= hilo_wr_data;
                end else begin
                    hi <= hilo_wr_data;
                end
            end
`endif
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        done       = fix_wr;
        hilo_rdata = hi0_lo1_sel ? lo : hi;
`ifdef MULDIV_MTHI_MTLO_EN
        stall = (busy && (hilo_rd || start || hilo_wr))
              || ((state == IDLE) && start && hilo_wr);
`else
        stall = busy && (hilo_rd || start);
`endif
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl (WIDTH=32,
// default build). Inputs change on the falling edge; outputs are sampled
// there too, away from the rising edge.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mul0_div1_sel;
    logic        unsigned_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hilo_rd;
    logic        hi0_lo1_sel;
    logic        flush;
    logic        busy;
    logic        stall;
    logic [31:0] hilo_rdata;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mul0_div1_sel (mul0_div1_sel),
        .unsigned_op   (unsigned_op),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .hilo_rd       (hilo_rd),
        .hi0_lo1_sel   (hi0_lo1_sel),
        .flush         (flush),
        .busy          (busy),
        .stall         (stall),
        .hilo_rdata    (hilo_rdata),
        .done          (done)
    );

    always @(negedge clk) if (done) done_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
        hi0_lo1_sel = 1'b0;
        #1 h = hilo_rdata;
        hi0_lo1_sel = 1'b1;
        #1 l = hilo_rdata;
    endtask

    // Presents one start, then counts the cycles busy stays high.
    task automatic run_op(input logic dv, input logic un, input logic [31:0] a,
                          input logic [31:0] b, output int bc);
        mul0_div1_sel = dv;
        unsigned_op   = un;
        rs_data       = a;
        rt_data       = b;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        while (busy && bc < 200) begin
            bc++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] h, l;
        int bc, sc, d0;

        rst_n = 1'b0; start = 1'b0; mul0_div1_sel = 1'b0; unsigned_op = 1'b0;
        rs_data = '0; rt_data = '0; hilo_rd = 1'b0; hi0_lo1_sel = 1'b0; flush = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        read_hl(h, l);
        chk("rst_hi", 64'(h), 64'd0);
        chk("rst_lo", 64'(l), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Signed MULT -2 x 3
        d0 = done_seen;
        run_op(1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000003, bc);
        chk("mult_busy_cycles", 64'(bc), 64'd33);
        chk("mult_done_pulses", 64'(done_seen - d0), 64'd1);
        read_hl(h, l);
        chk("mult_hi", 64'(h), 64'hFFFFFFFF);
        chk("mult_lo", 64'(l), 64'hFFFFFFFA);

        // MULTU max x max
        @(negedge clk);
        run_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, bc);
        read_hl(h, l);
        chk("multu_hi", 64'(h), 64'hFFFFFFFE);
        chk("multu_lo", 64'(l), 64'h00000001);

        // Signed DIV -7 / 2
        @(negedge clk);
        run_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, bc);
        chk("div_busy_cycles", 64'(bc), 64'd33);
        read_hl(h, l);
        chk("div_lo", 64'(l), 64'hFFFFFFFD);
        chk("div_hi", 64'(h), 64'hFFFFFFFF);

        // Signed overflow divide
        @(negedge clk);
        run_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, bc);
        read_hl(h, l);
        chk("divovf_lo", 64'(l), 64'h80000000);
        chk("divovf_hi", 64'(h), 64'h00000000);

        // DIVU by zero
        @(negedge clk);
        d0 = done_seen;
        run_op(1'b1, 1'b1, 32'd5, 32'd0, bc);
        chk("div0_busy_cycles", 64'(bc), 64'd1);
        chk("div0_done_pulses", 64'(done_seen - d0), 64'd1);
        read_hl(h, l);
        chk("div0_lo", 64'(l), 64'hFFFFFFFF);
        chk("div0_hi", 64'(h), 64'd5);

        // DIVU 100 / 7
        @(negedge clk);
        run_op(1'b1, 1'b1, 32'd100, 32'd7, bc);
        read_hl(h, l);
        chk("divu_lo", 64'(l), 64'd14);
        chk("divu_hi", 64'(h), 64'd2);

        // Signed DIV 7 / -2
        @(negedge clk);
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFE, bc);
        read_hl(h, l);
        chk("divneg_lo", 64'(l), 64'hFFFFFFFD);
        chk("divneg_hi", 64'(h), 64'd1);

        // start + MFLO in IDLE: no stall, old LO; then ignored start while
        // busy; then MFLO stalls until the product lands.
        @(negedge clk);
        d0 = done_seen;
        mul0_div1_sel = 1'b0; unsigned_op = 1'b0;
        rs_data = 32'd3; rt_data = 32'd4;
        start = 1'b1; hilo_rd = 1'b1; hi0_lo1_sel = 1'b1;
        #1;
        chk("idle_rd_stall", 64'(stall), 64'd0);
        chk("idle_rd_data", 64'(hilo_rdata), 64'hFFFFFFFD);
        @(negedge clk);
        start = 1'b0; hilo_rd = 1'b0;
        @(negedge clk);
        rs_data = 32'd5; rt_data = 32'd5; start = 1'b1;
        #1;
        chk("busy_start_stall", 64'(stall), 64'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        hilo_rd = 1'b1; hi0_lo1_sel = 1'b1;
        sc = 0;
        #1;
        while (stall && sc < 200) begin
            sc++;
            @(negedge clk);
            #1;
        end
        chk("mflo_stall_cycles", 64'(sc), 64'd29);
        chk("mflo_stall_low", 64'(stall), 64'd0);
        chk("mflo_data", 64'(hilo_rdata), 64'd12);
        chk("mflo_done_pulses", 64'(done_seen - d0), 64'd1);
        hilo_rd = 1'b0;

        // Flush at cycle 10 of a DIV
        @(negedge clk);
        d0 = done_seen;
        mul0_div1_sel = 1'b1; unsigned_op = 1'b1;
        rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("flush_stays_idle", 64'(busy), 64'd0);
        read_hl(h, l);
        chk("flush_hi", 64'(h), 64'd0);
        chk("flush_lo", 64'(l), 64'd12);
        chk("flush_no_done", 64'(done_seen - d0), 64'd0);

        // Reset at cycle 10 of a DIV, then a normal operation
        @(negedge clk);
        d0 = done_seen;
        mul0_div1_sel = 1'b1; unsigned_op = 1'b0;
        rs_data = 32'hFFFFFFF9; rt_data = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_hl(h, l);
        chk("rstmid_hi", 64'(h), 64'd0);
        chk("rstmid_lo", 64'(l), 64'd0);
        chk("rstmid_no_done", 64'(done_seen - d0), 64'd0);
        @(negedge clk);
        run_op(1'b1, 1'b1, 32'd100, 32'd7, bc);
        chk("post_rst_busy_cycles", 64'(bc), 64'd33);
        read_hl(h, l);
        chk("post_rst_lo", 64'(l), 64'd14);
        chk("post_rst_hi", 64'(h), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
